// File: rtl/argmax_frame_ctrl.sv
// Argmax frame controller: deserialises score beats, waits out the
// Argmax latency, captures the max and decodes its class index.
module argmax_frame_ctrl #(
  parameter int width   = 25,
  parameter int ARG_LAT = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [width-1:0] s_data,
  input  logic             s_last,
  output logic [width-1:0] score0,
  output logic [width-1:0] score1,
  output logic [width-1:0] score2,
  output logic [width-1:0] score3,
  output logic [width-1:0] score4,
  output logic [width-1:0] score5,
  input  logic [width-1:0] max_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [width-1:0] m_max,
  output logic [2:0]       m_index,
  output logic             m_trunc
);

  localparam int WW = $clog2(ARG_LAT + 2);

  typedef enum logic [1:0] {
    COLLECT,
    WAIT,
    CAPTURE,
    RESULT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       bcnt;
  logic [WW-1:0]    wcnt;
  logic [width-1:0] sc [6];
  logic             beat;
  logic             close;
  logic             hit;
  logic [2:0]       idx;

  assign s_ready = (state_q == COLLECT);
  assign beat    = s_valid & s_ready;
  assign close   = beat & (s_last | (bcnt == 3'd5));

  assign score0 = sc[0];
  assign score1 = sc[1];
  assign score2 = sc[2];
  assign score3 = sc[3];
  assign score4 = sc[4];
  assign score5 = sc[5];

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (close) state_d = WAIT;
      WAIT:    if (wcnt <= WW'(1)) state_d = CAPTURE;
      CAPTURE: state_d = RESULT;
      RESULT:  if (m_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Lowest matching slot wins; no match falls back to 0
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (sc[i] == max_in) begin
        idx = 3'(i);
        hit = 1'b1;
      end
    end
  end

  // Beat counter, latency counter and score slots
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bcnt <= '0;
      wcnt <= '0;
      for (int i = 0; i < 6; i++) sc[i] <= '0;
    end else begin
      if (beat) begin
        if (bcnt == 3'd0)
          for (int i = 0; i < 6; i++) sc[i] <= '0;
        sc[bcnt] <= s_data;
      end
      if (close)     bcnt <= '0;
      else if (beat) bcnt <= bcnt + 3'd1;
      if (close)
        wcnt <= WW'(ARG_LAT);
      else if (state_q == WAIT && wcnt != '0)
        wcnt <= wcnt - WW'(1);
    end
  end

  // Result registers and handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_max   <= '0;
      m_index <= '0;
      m_trunc <= 1'b0;
    end else begin
      if (close)
        m_trunc <= (bcnt == 3'd5) & ~s_last;
      if (state_q == CAPTURE) begin
        m_max   <= max_in;
        m_index <= idx;
        m_valid <= 1'b1;
      end else if (state_q == RESULT && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Argmax must agree with one of the held scores
  always_ff @(posedge clk) begin
    if (rstn && state_q == CAPTURE) assert (hit);
  end

endmodule

// File: tb/tb_argmax_frame_ctrl.sv
// Directed bench for argmax_frame_ctrl with a 3-stage Argmax model.
// Expected results are hand-computed per frame.
module tb_argmax_frame_ctrl;

  logic        clk = 0;
  logic        rstn = 0;
  logic        s_valid = 0;
  logic        s_ready;
  logic [24:0] s_data = '0;
  logic        s_last = 0;
  logic [24:0] score0, score1, score2;
  logic [24:0] score3, score4, score5;
  logic [24:0] max_in;
  logic        m_valid;
  logic        m_ready = 0;
  logic [24:0] m_max;
  logic [2:0]  m_index;
  logic        m_trunc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  argmax_frame_ctrl dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .score0(score0), .score1(score1), .score2(score2),
    .score3(score3), .score4(score4), .score5(score5),
    .max_in(max_in),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_max(m_max), .m_index(m_index), .m_trunc(m_trunc)
  );

  // 3-stage Argmax stand-in
  logic [24:0] p0 = '0, p1 = '0, p2 = '0;
  logic [24:0] cmax;
  always_comb begin
    cmax = score0;
    if (score1 > cmax) cmax = score1;
    if (score2 > cmax) cmax = score2;
    if (score3 > cmax) cmax = score3;
    if (score4 > cmax) cmax = score4;
    if (score5 > cmax) cmax = score5;
  end
  always @(posedge clk) begin
    p0 <= cmax;
    p1 <= p0;
    p2 <= p1;
  end
  assign max_in = p2;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [24:0] d, input bit last);
    chk("s_ready_beat", 32'(s_ready), 1);
    s_valid = 1;
    s_data  = d;
    s_last  = last;
    @(posedge clk);
    #1;
    s_valid = 0;
    s_last  = 0;
  endtask

  task automatic expect_res(input logic [24:0] emax,
                            input logic [2:0] eidx,
                            input bit etr);
    int n;
    n = 0;
    while (!m_valid && n < 20) begin
      chk("s_ready_wait", 32'(s_ready), 0);
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 4);
    chk("m_max", 32'(m_max), 32'(emax));
    chk("m_index", 32'(m_index), 32'(eidx));
    chk("m_trunc", 32'(m_trunc), 32'(etr));
  endtask

  task automatic accept();
    m_ready = 1;
    @(posedge clk);
    #1;
    m_ready = 0;
    chk("m_valid_drop", 32'(m_valid), 0);
    chk("s_ready_back", 32'(s_ready), 1);
  endtask

  initial begin
    #2;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_max", 32'(m_max), 0);
    chk("rst_m_index", 32'(m_index), 0);
    chk("rst_m_trunc", 32'(m_trunc), 0);
    chk("rst_score0", 32'(score0), 0);
    @(posedge clk);
    #1;
    rstn = 1;
    @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 1);

    // ascending frame, max in last slot
    send(10, 0); send(20, 0); send(30, 0);
    send(40, 0); send(50, 0); send(60, 1);
    chk("asc_score5", 32'(score5), 60);
    expect_res(60, 5, 0);
    accept();

    // max in first slot
    send(900, 0); send(1, 0); send(2, 0);
    send(3, 0); send(4, 0); send(5, 1);
    expect_res(900, 0, 0);
    accept();

    // all-ones score in slot 3
    send(900, 0); send(1, 0); send(2, 0);
    send(25'h1FFFFFF, 0); send(4, 0); send(5, 1);
    expect_res(25'h1FFFFFF, 3, 0);
    accept();

    // tie resolves low, with 10 cycles of backpressure
    send(7, 0); send(42, 0); send(42, 0);
    send(3, 0); send(42, 0); send(0, 1);
    expect_res(42, 1, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_m_valid", 32'(m_valid), 1);
      chk("bp_m_max", 32'(m_max), 42);
      chk("bp_m_index", 32'(m_index), 1);
      chk("bp_s_ready", 32'(s_ready), 0);
    end
    accept();

    // short frame clears the unfilled slots
    send(5, 0); send(99, 0); send(12, 1);
    chk("short_score0", 32'(score0), 5);
    chk("short_score2", 32'(score2), 12);
    chk("short_score3", 32'(score3), 0);
    chk("short_score4", 32'(score4), 0);
    chk("short_score5", 32'(score5), 0);
    expect_res(99, 1, 0);
    accept();

    // seven beats with no s_last: six truncate, seventh opens a frame
    send(1, 0); send(2, 0); send(3, 0);
    send(4, 0); send(5, 0); send(6, 0);
    expect_res(6, 5, 1);
    accept();
    send(77, 0);
    send(3, 1);
    chk("next_score1", 32'(score1), 3);
    chk("next_score2", 32'(score2), 0);
    expect_res(77, 0, 0);
    accept();

    // reset one edge after the closing beat
    send(8, 0); send(9, 1);
    @(posedge clk);
    #1;
    rstn = 0;
    #1;
    chk("mid_rst_m_max", 32'(m_max), 0);
    chk("mid_rst_m_valid", 32'(m_valid), 0);
    chk("mid_rst_score1", 32'(score1), 0);
    @(posedge clk);
    #1;
    rstn = 1;
    chk("post_rst_s_ready", 32'(s_ready), 1);
    chk("post_rst_m_index", 32'(m_index), 0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_res", 32'(m_valid), 0);
    end
    send(11, 0); send(22, 0); send(33, 0);
    send(44, 0); send(55, 0); send(19, 1);
    expect_res(55, 4, 0);
    accept();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
